// File: rtl/transition_pair_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : transition_pair_sequencer_if
// Description : Handshake and stimulus bundle between the transition pair
//               sequencer and the consumer that captures its output.
//               master : sequencer side (drives the stimulus, receives start/stall)
//               slave  : consumer side (drives start/stall, receives stimulus)
// Signals     : start, stall            consumer -> sequencer
//               vec_out[N_IN], phase     sequencer -> consumer (DUT vector)
//               sim_begin, sim_end       window markers
//               sim_idx[IDXW]            pair index i*SIM + j
//               busy, done               sweep status
// Revision    : 1.0 - initial release
// ============================================================================
interface transition_pair_sequencer_if #(
  parameter int N_IN = 4,
  parameter int IDXW = 2 * N_IN
);
  logic            start;
  logic            stall;
  logic [N_IN-1:0] vec_out;
  logic            phase;
  logic            sim_begin;
  logic            sim_end;
  logic [IDXW-1:0] sim_idx;
  logic            busy;
  logic            done;

  modport master (
    input  start, stall,
    output vec_out, phase, sim_begin, sim_end, sim_idx, busy, done
  );

  modport slave (
    output start, stall,
    input  vec_out, phase, sim_begin, sim_end, sim_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/transition_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : transition_pair_sequencer
// Description : Sweeps every ordered pair (i, j) of input vectors 0..SIM-1.
//               Each pair drives vector i for HOLD cycles (initial phase)
//               then vector j for HOLD cycles (final phase), marking the
//               last cycle of each phase with sim_begin / sim_end.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - transition_pair_sequencer_if.master
//                        (start, stall in; vec_out, phase, sim_begin,
//                         sim_end, sim_idx, busy, done out)
// Revision    : 1.0 - initial release
// ============================================================================
module transition_pair_sequencer #(
  parameter int N_IN = 4,
  parameter int SIM  = 16,
  parameter int HOLD = 5,
  parameter int IDXW = 2 * N_IN
) (
  input wire logic                       clk,
  input wire logic                       rst_n,
  transition_pair_sequencer_if.master    bus
);

  localparam int CW = (SIM  > 1) ? $clog2(SIM)  : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] c_SIM_LAST  = CW'(SIM - 1);
  localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_i;
  logic [CW-1:0]   r_j;
  logic [HW-1:0]   r_hold;
  logic [N_IN-1:0] r_vec;
  logic            r_phase;
  logic [IDXW-1:0] r_idx;
  logic            r_busy;
  logic            r_done;

  logic            w_hold_term;
  logic [CW-1:0]   w_i_inc;

  // A phase ends on its last hold cycle, but only once the consumer is ready.
  assign w_hold_term = (r_hold == c_HOLD_LAST) && !bus.stall;
  assign w_i_inc     = r_i + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_hold  <= '0;
      r_vec   <= '0;
      r_phase <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_INIT;
            r_i     <= '0;
            r_j     <= '0;
            r_hold  <= '0;
            r_vec   <= '0;
            r_phase <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end

        S_INIT: begin
          if (!bus.stall) begin
            if (!w_hold_term) begin
              r_hold <= r_hold + HW'(1);
            end else begin
              r_state <= S_FINAL;
              r_hold  <= '0;
              r_vec   <= N_IN'(r_j);
              r_phase <= 1'b1;
            end
          end
        end

        S_FINAL: begin
          if (!bus.stall) begin
            if (!w_hold_term) begin
              r_hold <= r_hold + HW'(1);
            end else begin
              r_hold <= '0;
              if (r_j != c_SIM_LAST) begin
                r_j     <= r_j + CW'(1);
                r_state <= S_INIT;
                r_vec   <= N_IN'(r_i);
                r_phase <= 1'b0;
                r_idx   <= r_idx + IDXW'(1);
              end else if (r_i != c_SIM_LAST) begin
                r_i     <= w_i_inc;
                r_j     <= '0;
                r_state <= S_INIT;
                r_vec   <= N_IN'(w_i_inc);
                r_phase <= 1'b0;
                r_idx   <= r_idx + IDXW'(1);
              end else begin
                // Last pair finished: vec_out and sim_idx keep their final values.
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.vec_out   = r_vec;
  assign bus.phase     = r_phase;
  assign bus.sim_idx   = r_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  // Markers are gated by the live stall so a stalled terminal cycle emits
  // nothing and the pulse lands on the first ready terminal cycle.
  assign bus.sim_begin = (r_state == S_INIT)  && w_hold_term;
  assign bus.sim_end   = (r_state == S_FINAL) && w_hold_term;

endmodule
`default_nettype wire

// File: tb/tb_transition_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_transition_pair_sequencer
// Description : Directed self-checking bench for transition_pair_sequencer.
//               Main instance N_IN=2, SIM=4, HOLD=2; edge instances
//               SIM=1/HOLD=1 and SIM=3/HOLD=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transition_pair_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  transition_pair_sequencer_if #(.N_IN(2), .IDXW(4)) m_if  ();
  transition_pair_sequencer_if #(.N_IN(2), .IDXW(4)) e1_if ();
  transition_pair_sequencer_if #(.N_IN(2), .IDXW(4)) e3_if ();

  transition_pair_sequencer #(.N_IN(2), .SIM(4), .HOLD(2), .IDXW(4)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  transition_pair_sequencer #(.N_IN(2), .SIM(1), .HOLD(1), .IDXW(4)) u_e1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (e1_if)
  );

  transition_pair_sequencer #(.N_IN(2), .SIM(3), .HOLD(2), .IDXW(4)) u_e3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (e3_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_if.start = c[0];
      #1;
      tests++;
      if ({m_if.vec_out, m_if.phase, m_if.sim_begin, m_if.sim_end,
           m_if.sim_idx, m_if.busy, m_if.done} !== 11'd0) begin
        fails++;
        $display("FAIL reset_hold: got %b required 0", {m_if.vec_out, m_if.phase,
                 m_if.sim_begin, m_if.sim_end, m_if.sim_idx, m_if.busy, m_if.done});
      end
      next_cycle();
    end
    m_if.start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    tests++;
    if ({m_if.busy, m_if.done, m_if.sim_idx, m_if.vec_out} !== 8'd0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b idx=%0d vec=%0d required all 0",
               m_if.busy, m_if.done, m_if.sim_idx, m_if.vec_out);
    end
    next_cycle();
  endtask

  task automatic run_sweep(input int stall_at, input int stall_len, input int busy_start_at,
                           input string name);
    int         total, eff, p, k, nb, ne;
    logic       stalled, exp_b, exp_e;
    logic [1:0] exp_vec;
    logic [8:0] exp_bus, got_bus;
    nb    = 0;
    ne    = 0;
    total = 64 + stall_len;
    m_if.start = 1'b1;
    next_cycle();
    m_if.start = 1'b0;
    for (int c = 0; c < total; c++) begin
      stalled    = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + stall_len);
      m_if.stall = stalled;
      m_if.start = (c == busy_start_at);
      if (stall_at >= 0 && c >= stall_at)
        eff = stalled ? stall_at : c - stall_len;
      else
        eff = c;
      p       = eff / 4;
      k       = eff % 4;
      exp_vec = (k < 2) ? 2'(p / 4) : 2'(p % 4);
      exp_b   = !stalled && (k == 1);
      exp_e   = !stalled && (k == 3);
      exp_bus = {exp_vec, (k >= 2), 4'(p), 1'b1, 1'b0};
      #1;
      got_bus = {m_if.vec_out, m_if.phase, m_if.sim_idx, m_if.busy, m_if.done};
      tests++;
      if (got_bus !== exp_bus) begin
        fails++;
        $display("FAIL %s_outputs cyc %0d: got vec/ph/idx/busy/done=%b required %b",
                 name, c, got_bus, exp_bus);
      end
      tests++;
      if (m_if.sim_begin !== exp_b || m_if.sim_end !== exp_e) begin
        fails++;
        $display("FAIL %s_markers cyc %0d: got begin=%b end=%b required begin=%b end=%b",
                 name, c, m_if.sim_begin, m_if.sim_end, exp_b, exp_e);
      end
      nb += int'(m_if.sim_begin);
      ne += int'(m_if.sim_end);
      next_cycle();
    end
    m_if.stall = 1'b0;
    m_if.start = 1'b0;
    #1;
    tests++;
    if ({m_if.vec_out, m_if.sim_idx, m_if.busy, m_if.done, m_if.sim_begin, m_if.sim_end}
        !== {2'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s_done: got vec=%0d idx=%0d busy=%b done=%b required vec=3 idx=15 busy=0 done=1",
               name, m_if.vec_out, m_if.sim_idx, m_if.busy, m_if.done);
    end
    tests++;
    if (nb != 16 || ne != 16) begin
      fails++;
      $display("FAIL %s_pulses: got begin=%0d end=%0d required 16 16", name, nb, ne);
    end
    next_cycle();
  endtask

  task automatic test_sweep();
    run_sweep(-1, 0, -1, "sweep");
  endtask

  // Begins from DONE, so cycle 0 also checks done drops on the restart edge.
  task automatic test_stall();
    run_sweep(21, 3, -1, "stall");
  endtask

  task automatic test_restart();
    run_sweep(-1, 0, 30, "restart");
  endtask

  task automatic test_reset_mid();
    m_if.start = 1'b1;
    next_cycle();
    m_if.start = 1'b0;
    for (int c = 0; c < 38; c++) next_cycle();
    #1;
    tests++;
    if ({m_if.phase, m_if.sim_idx, m_if.vec_out} !== {1'b1, 4'd9, 2'd1}) begin
      fails++;
      $display("FAIL midrst_pre: got phase=%b idx=%0d vec=%0d required phase=1 idx=9 vec=1",
               m_if.phase, m_if.sim_idx, m_if.vec_out);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({m_if.vec_out, m_if.phase, m_if.sim_begin, m_if.sim_end,
         m_if.sim_idx, m_if.busy, m_if.done} !== 11'd0) begin
      fails++;
      $display("FAIL midrst_async: got %b required 0", {m_if.vec_out, m_if.phase,
               m_if.sim_begin, m_if.sim_end, m_if.sim_idx, m_if.busy, m_if.done});
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #1;
    tests++;
    if ({m_if.busy, m_if.done} !== 2'b00) begin
      fails++;
      $display("FAIL midrst_idle: got busy=%b done=%b required 0 0", m_if.busy, m_if.done);
    end
    next_cycle();
    run_sweep(-1, 0, -1, "after_rst");
  endtask

  task automatic test_edge_sim1();
    e1_if.start = 1'b1;
    next_cycle();
    e1_if.start = 1'b0;
    #1;
    tests++;
    if ({e1_if.sim_begin, e1_if.sim_end, e1_if.phase, e1_if.busy, e1_if.done} !== 5'b10010) begin
      fails++;
      $display("FAIL sim1_begin: got b/e/ph/busy/done=%b required 10010",
               {e1_if.sim_begin, e1_if.sim_end, e1_if.phase, e1_if.busy, e1_if.done});
    end
    next_cycle();
    #1;
    tests++;
    if ({e1_if.sim_begin, e1_if.sim_end, e1_if.phase, e1_if.busy, e1_if.done} !== 5'b01110) begin
      fails++;
      $display("FAIL sim1_end: got b/e/ph/busy/done=%b required 01110",
               {e1_if.sim_begin, e1_if.sim_end, e1_if.phase, e1_if.busy, e1_if.done});
    end
    next_cycle();
    #1;
    tests++;
    if ({e1_if.sim_end, e1_if.busy, e1_if.done, e1_if.sim_idx, e1_if.vec_out} !== {3'b001, 4'd0, 2'd0}) begin
      fails++;
      $display("FAIL sim1_done: got end=%b busy=%b done=%b idx=%0d vec=%0d required 0 0 1 0 0",
               e1_if.sim_end, e1_if.busy, e1_if.done, e1_if.sim_idx, e1_if.vec_out);
    end
    next_cycle();
  endtask

  task automatic test_edge_sim3();
    int ne, nb, bad_vec;
    ne = 0;
    nb = 0;
    bad_vec = 0;
    e3_if.start = 1'b1;
    next_cycle();
    e3_if.start = 1'b0;
    for (int c = 0; c < 36; c++) begin
      #1;
      if (e3_if.vec_out == 2'd3) bad_vec++;
      if (e3_if.done) bad_vec++;
      if (e3_if.sim_begin) begin
        tests++;
        if (e3_if.sim_idx !== 4'(nb)) begin
          fails++;
          $display("FAIL sim3_idx: got %0d required %0d", e3_if.sim_idx, nb);
        end
        nb++;
      end
      ne += int'(e3_if.sim_end);
      next_cycle();
    end
    #1;
    tests++;
    if (bad_vec != 0) begin
      fails++;
      $display("FAIL sim3_vec: got %0d cycles with vec=3 or early done required 0", bad_vec);
    end
    tests++;
    if (nb != 9 || ne != 9) begin
      fails++;
      $display("FAIL sim3_pairs: got begin=%0d end=%0d required 9 9", nb, ne);
    end
    tests++;
    if ({e3_if.done, e3_if.sim_idx, e3_if.vec_out} !== {1'b1, 4'd8, 2'd2}) begin
      fails++;
      $display("FAIL sim3_done: got done=%b idx=%0d vec=%0d required 1 8 2",
               e3_if.done, e3_if.sim_idx, e3_if.vec_out);
    end
    next_cycle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    m_if.start  = 1'b0;  m_if.stall  = 1'b0;
    e1_if.start = 1'b0;  e1_if.stall = 1'b0;
    e3_if.start = 1'b0;  e3_if.stall = 1'b0;
    next_cycle();
    test_reset();
    test_sweep();
    test_stall();
    test_restart();
    test_reset_mid();
    test_edge_sim1();
    test_edge_sim3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/transition_pair_sequencer.md
Name: transition_pair_sequencer

Overview:
- Synchronous stimulus generator upstream of the gate-level correlation DUT.
- Sweeps every ordered pair (i, j) of input vectors: drives vector i for HOLD cycles (initial phase), then vector j for HOLD cycles (final phase).
- Emits begin/end markers around each transition window, so the downstream power/VCD capture can tag each window with its simulation index.
- Replaces the nested-loop stimulus in benches; the identical sequence is also available in hardware.

Parameters:
- N_IN, 4, width of the DUT input vector {a, b, r1, r2}.
- SIM, 16, number of vectors iterated per loop level; legal range 1..2**N_IN; vectors used are 0..SIM-1.
- HOLD, 5, cycles each vector is held; legal range ≥1.
- IDXW, 2*N_IN, width of the simulation index; must satisfy 2**IDXW ≥ SIM*SIM.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; sampled in IDLE or DONE only.
- stall  input  1  consumer not ready; freezes the sequencer while high.
- vec_out  output  N_IN  vector driven to the DUT; MSB→a … LSB→r2.
- phase  output  1  0 = initial vector i, 1 = final vector j.
- sim_begin  output  1  one-cycle pulse on the last initial-phase cycle of each pair.
- sim_end  output  1  one-cycle pulse on the last final-phase cycle of each pair.
- sim_idx  output  IDXW  index of the current pair, i*SIM + j.
- busy  output  1  high in INIT or FINAL.
- done  output  1  high in DONE.

Behaviour:
- Reset: async assert of rst_n forces IDLE immediately. vec_out, phase, sim_begin, sim_end, sim_idx, busy and done are all 0. Internal i, j and hold_cnt are 0.
- States: IDLE, INIT, FINAL, DONE. All outputs are registered.
- IDLE, start=1: next cycle enters INIT with i=j=0, hold_cnt=0, sim_idx=0.
- INIT:
  - vec_out=i, phase=0, busy=1.
  - On a cycle with stall=0 and hold_cnt<HOLD-1: hold_cnt increments.
  - On a cycle with stall=0 and hold_cnt=HOLD-1: sim_begin=1 on that same cycle (combinational from state and count, with the registered outputs gated). Next cycle: FINAL, hold_cnt=0, vec_out=j.
- FINAL:
  - vec_out=j, phase=1.
  - On a cycle with stall=0 and hold_cnt=HOLD-1: sim_end=1.
  - Next step at that point:
    - j<SIM-1: j+1, back to INIT.
    - else if i<SIM-1: j=0, i+1, INIT.
    - else: DONE.
  - sim_idx increments on every INIT re-entry.
- DONE:
  - done=1, busy=0.
  - vec_out holds the last j; sim_idx holds SIM*SIM-1.
  - start=1 restarts exactly as from IDLE, with done dropping on the same edge.
- stall=1:
  - hold_cnt, i, j, state and all outputs freeze.
  - sim_begin and sim_end are forced to 0 on stalled cycles; a pulse fires on the first unstalled terminal cycle.
  - stall is ignored in IDLE and DONE.
- start while busy: ignored; no restart and no count disturbance.
- HOLD=1: every cycle with stall=0 is terminal, so sim_begin and sim_end alternate on consecutive cycles.
- SIM=1: a single pair (0,0) runs, then DONE.
- Total sweep length with no stall: 2*HOLD*SIM*SIM cycles from INIT entry to DONE entry.
- Count widths: i, j use clog2(SIM) bits (min 1); hold_cnt uses clog2(HOLD) bits (min 1); no wrap beyond terminal values.
- Reset mid-sweep: immediate IDLE, all outputs 0. The partial sweep is discarded; no sim_end is emitted.

Test Plan:
- Reset: hold rst_n=0 with start=1 toggling → every output 0, no state change. Release rst_n → stays IDLE until start.
- N_IN=2, SIM=4, HOLD=2, start pulse, no stall:
  - 16 sim_begin and 16 sim_end pulses.
  - vec_out sequence 0,0,0,0 | 0,0,1,1 | … | 3,3,3,3.
  - sim_idx runs 0..15.
  - done rises exactly 64 cycles after INIT entry.
- Stall:
  - Assert stall for 3 cycles on the terminal INIT cycle of pair 5 → sim_begin is suppressed during the stall and fires once on release.
  - Total sweep is 64+3 cycles; vec_out is stable through the stall.
- Restart: start during busy → ignored. start in DONE → sweep repeats with sim_idx back to 0 and done low the next cycle.
- Reset mid-op: drop rst_n while in FINAL of pair 9 → all outputs 0 asynchronously, before the next clk edge. Next sweep starts at pair 0.
- Edge parameters:
  - SIM=1, HOLD=1: sim_begin then sim_end on consecutive cycles, DONE after 2 cycles.
  - SIM=3 with N_IN=2: vector 3 is never driven, and 9 pairs complete.
